reg_wb_arbiter: RTL and testbench

Write-back arbiter and scoreboard that owns the single write port of the integer register bank. It merges single-cycle ALU results and multi-cycle LSU results onto one registered write port (address, data, enable). It also tracks registers with outstanding multi-cycle writes, so that decode can stall on read-after-write hazards. It sits between the execute/LSU stages and the register bank, on the writer side of the bank's write interface.

---
 rtl/reg_wb_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_reg_wb_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_wb_arbiter.sv
// Write-back arbiter: merges ALU and buffered LSU results onto the register bank write port and
// tracks destinations of outstanding multi-cycle ops. Optional macro WB_FWD_EN adds write-port forwarding flags.
module reg_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int WORD_WIDTH = 32,
    parameter int N_OF_REGS  = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid_i,
    input  logic [ADDR_WIDTH-1:0] alu_addr_i,
    input  logic [WORD_WIDTH-1:0] alu_data_i,
    input  logic                  lsu_valid_i,
    output logic                  lsu_ready_o,
    input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
    input  logic [WORD_WIDTH-1:0] lsu_data_i,
    input  logic                  issue_i,
    input  logic [ADDR_WIDTH-1:0] issue_addr_i,
    input  logic [ADDR_WIDTH-1:0] rs1_addr_i,
    input  logic [ADDR_WIDTH-1:0] rs2_addr_i,
    output logic                  hazard_o,
`ifdef WB_FWD_EN
    output logic                  fwd1_o,
    output logic                  fwd2_o,
`endif
    output logic [ADDR_WIDTH-1:0] addr_wd_o,
    output logic [WORD_WIDTH-1:0] wd_o,
    output logic                  wen_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0]      PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]      CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0]      CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = {ADDR_WIDTH{1'b0}};
    localparam logic [WORD_WIDTH-1:0] ZERO_WORD = {WORD_WIDTH{1'b0}};

    logic [ADDR_WIDTH-1:0] fifo_addr_r [FIFO_DEPTH];
    logic [WORD_WIDTH-1:0] fifo_data_r [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic                  full_s;
    logic                  push_s;
    logic                  pop_s;

    logic                  sel_valid_s;
    logic                  sel_lsu_s;
    logic [ADDR_WIDTH-1:0] sel_addr_s;
    logic [WORD_WIDTH-1:0] sel_data_s;

    logic [ADDR_WIDTH-1:0] addr_wd_r;
    logic [WORD_WIDTH-1:0] wd_r;
    logic                  wen_r;
    logic                  wen_lsu_r;

    logic [N_OF_REGS-1:0]  pending_r;
    logic [N_OF_REGS-1:0]  pending_next_s;
    logic                  fwd1_s;
    logic                  fwd2_s;
    logic                  haz1_s;
    logic                  haz2_s;

    // FIFO handshake: ready depends on occupancy only; the ALU blocks the pop
    always_comb begin
        full_s = (count_r == CNT_FULL);
        push_s = lsu_valid_i && !full_s;
        pop_s  = !alu_valid_i && (count_r != CNT_ZERO);
    end

    // Write-port selection with strict ALU priority
    always_comb begin
        sel_valid_s = 1'b0;
        sel_lsu_s   = 1'b0;
        sel_addr_s  = addr_wd_r;
        sel_data_s  = wd_r;
        if (alu_valid_i) begin
            sel_valid_s = 1'b1;
            sel_addr_s  = alu_addr_i;
            sel_data_s  = alu_data_i;
        end else if (pop_s) begin
            sel_valid_s = 1'b1;
            sel_lsu_s   = 1'b1;
            sel_addr_s  = fifo_addr_r[rd_ptr_r];
            sel_data_s  = fifo_data_r[rd_ptr_r];
        end else begin
            sel_valid_s = 1'b0;
        end
    end

    // FIFO storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_addr_r[i] <= ZERO_ADDR;
                fifo_data_r[i] <= ZERO_WORD;
            end
        end else if (push_s) begin
            fifo_addr_r[wr_ptr_r] <= lsu_addr_i;
            fifo_data_r[wr_ptr_r] <= lsu_data_i;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Registered write port; x0 is consumed but never enabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_wd_r <= ZERO_ADDR;
            wd_r      <= ZERO_WORD;
            wen_r     <= 1'b0;
            wen_lsu_r <= 1'b0;
        end else if (sel_valid_s) begin
            addr_wd_r <= sel_addr_s;
            wd_r      <= sel_data_s;
            wen_r     <= (sel_addr_s != ZERO_ADDR);
            wen_lsu_r <= sel_lsu_s && (sel_addr_s != ZERO_ADDR);
        end else begin
            wen_r     <= 1'b0;
            wen_lsu_r <= 1'b0;
        end
    end

    // Scoreboard update: clear on LSU commit, then set on issue so set wins
    always_comb begin
        pending_next_s = pending_r;
        if (wen_r && wen_lsu_r) begin
            pending_next_s[addr_wd_r] = 1'b0;
        end else begin
            pending_next_s = pending_r;
        end
        if (issue_i && (issue_addr_i != ZERO_ADDR)) begin
            pending_next_s[issue_addr_i] = 1'b1;
        end else begin
            pending_next_s[0] = pending_next_s[0];
        end
    end

    // Scoreboard state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_r <= {N_OF_REGS{1'b0}};
        end else begin
            pending_r <= pending_next_s;
        end
    end

    // Hazard detection; a forwarded source needs no stall
    always_comb begin
        fwd1_s = 1'b0;
        fwd2_s = 1'b0;
`ifdef WB_FWD_EN
        fwd1_s = wen_r && (addr_wd_r == rs1_addr_i) && (rs1_addr_i != ZERO_ADDR);
        fwd2_s = wen_r && (addr_wd_r == rs2_addr_i) && (rs2_addr_i != ZERO_ADDR);
`endif
        if (rs1_addr_i != ZERO_ADDR) begin
            haz1_s = pending_r[rs1_addr_i] && !fwd1_s;
        end else begin
            haz1_s = 1'b0;
        end
        if (rs2_addr_i != ZERO_ADDR) begin
            haz2_s = pending_r[rs2_addr_i] && !fwd2_s;
        end else begin
            haz2_s = 1'b0;
        end
    end

    assign lsu_ready_o = !full_s;
    assign hazard_o    = haz1_s || haz2_s;
    assign addr_wd_o   = addr_wd_r;
    assign wd_o        = wd_r;
    assign wen_o       = wen_r;
`ifdef WB_FWD_EN
    assign fwd1_o      = fwd1_s;
    assign fwd2_o      = fwd2_s;
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a queue-based model.
module tb_reg_wb_arbiter;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid_i;
    logic [4:0]  alu_addr_i;
    logic [31:0] alu_data_i;
    logic        lsu_valid_i;
    logic        lsu_ready_o;
    logic [4:0]  lsu_addr_i;
    logic [31:0] lsu_data_i;
    logic        issue_i;
    logic [4:0]  issue_addr_i;
    logic [4:0]  rs1_addr_i;
    logic [4:0]  rs2_addr_i;
    logic        hazard_o;
    logic [4:0]  addr_wd_o;
    logic [31:0] wd_o;
    logic        wen_o;
`ifdef WB_FWD_EN
    logic        fwd1_o;
    logic        fwd2_o;
`endif

    int total = 0;
    int bad   = 0;

    reg_wb_arbiter #(.ADDR_WIDTH(5), .WORD_WIDTH(32), .N_OF_REGS(32), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid_i(alu_valid_i), .alu_addr_i(alu_addr_i), .alu_data_i(alu_data_i),
        .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
        .lsu_addr_i(lsu_addr_i), .lsu_data_i(lsu_data_i),
        .issue_i(issue_i), .issue_addr_i(issue_addr_i),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
        .hazard_o(hazard_o),
`ifdef WB_FWD_EN
        .fwd1_o(fwd1_o), .fwd2_o(fwd2_o),
`endif
        .addr_wd_o(addr_wd_o), .wd_o(wd_o), .wen_o(wen_o)
    );

    always #5 clk = ~clk;

    // Model: LSU results waiting, the expected write port, and the set of pending registers
    logic [4:0]  q_addr[$];
    logic [31:0] q_data[$];
    logic        m_wen;
    logic        m_from_lsu;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    bit          m_pend[32];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit src_haz(input logic [4:0] rs);
        bit h;
        h = (rs != 5'd0) && m_pend[rs];
`ifdef WB_FWD_EN
        if (m_wen && (m_addr == rs)) h = 1'b0;
`endif
        return h;
    endfunction

    task automatic model_reset();
        q_addr.delete();
        q_data.delete();
        m_wen = 1'b0;
        m_from_lsu = 1'b0;
        m_addr = 5'd0;
        m_data = 32'd0;
        foreach (m_pend[i]) m_pend[i] = 1'b0;
    endtask

    task automatic model_step();
        bit push;
        push = lsu_valid_i && (q_addr.size() < DEPTH);
        if (m_wen && m_from_lsu) m_pend[m_addr] = 1'b0;
        if (issue_i && issue_addr_i != 5'd0) m_pend[issue_addr_i] = 1'b1;
        if (alu_valid_i) begin
            m_addr = alu_addr_i;
            m_data = alu_data_i;
            m_wen = (alu_addr_i != 5'd0);
            m_from_lsu = 1'b0;
        end else if (q_addr.size() > 0) begin
            m_addr = q_addr.pop_front();
            m_data = q_data.pop_front();
            m_wen = (m_addr != 5'd0);
            m_from_lsu = 1'b1;
        end else begin
            m_wen = 1'b0;
            m_from_lsu = 1'b0;
        end
        if (push) begin
            q_addr.push_back(lsu_addr_i);
            q_data.push_back(lsu_data_i);
        end
    endtask

    task automatic check_all();
        chk("m_ready", lsu_ready_o, (q_addr.size() < DEPTH));
        chk("m_wen", wen_o, m_wen);
        if (m_wen) begin
            chk("m_addr", addr_wd_o, m_addr);
            chk("m_data", wd_o, m_data);
        end
        chk("m_hazard", hazard_o, src_haz(rs1_addr_i) || src_haz(rs2_addr_i));
`ifdef WB_FWD_EN
        chk("m_fwd1", fwd1_o, m_wen && m_addr == rs1_addr_i && rs1_addr_i != 5'd0);
        chk("m_fwd2", fwd2_o, m_wen && m_addr == rs2_addr_i && rs2_addr_i != 5'd0);
`endif
    endtask

    // One clock: compare against the model mid-cycle, advance the model, step past the edge
    task automatic cyc();
        @(negedge clk);
        if (!rst) check_all();
        if (rst) model_reset();
        else model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid_i = 1'b0; alu_addr_i = 5'd0; alu_data_i = 32'd0;
        lsu_valid_i = 1'b0; lsu_addr_i = 5'd0; lsu_data_i = 32'd0;
        issue_i = 1'b0; issue_addr_i = 5'd0;
        rs1_addr_i = 5'd0; rs2_addr_i = 5'd0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("rst_wen", wen_o, 1'b0);
        chk("rst_addr", addr_wd_o, 5'd0);
        chk("rst_data", wd_o, 32'd0);
        chk("rst_ready", lsu_ready_o, 1'b1);
        chk("rst_hazard", hazard_o, 1'b0);

        // ALU priority over a simultaneous LSU result
        alu_valid_i = 1'b1; alu_addr_i = 5'd3; alu_data_i = 32'h11;
        lsu_valid_i = 1'b1; lsu_addr_i = 5'd4; lsu_data_i = 32'h22;
        cyc();
        idle();
        chk("prio_wen1", wen_o, 1'b1);
        chk("prio_addr1", addr_wd_o, 5'd3);
        chk("prio_data1", wd_o, 32'h11);
        cyc();
        chk("prio_wen2", wen_o, 1'b1);
        chk("prio_addr2", addr_wd_o, 5'd4);
        chk("prio_data2", wd_o, 32'h22);
        cyc();
        chk("prio_idle", wen_o, 1'b0);

        // FIFO fills behind continuous ALU writes, then drains in order
        for (int i = 0; i < 3; i++) begin
            alu_valid_i = 1'b1; alu_addr_i = 5'd1; alu_data_i = 32'(i);
            lsu_valid_i = 1'b1; lsu_addr_i = 5'(7 + i); lsu_data_i = 32'h100 * (7 + i);
            cyc();
        end
        chk("full_ready", lsu_ready_o, 1'b0);
        idle();
        cyc();
        chk("drain_ready", lsu_ready_o, 1'b1);
        chk("drain_addr1", addr_wd_o, 5'd7);
        chk("drain_data1", wd_o, 32'h700);
        cyc();
        chk("drain_addr2", addr_wd_o, 5'd8);
        chk("drain_data2", wd_o, 32'h800);
        cyc();
        chk("drain_end", wen_o, 1'b0);

        // Scoreboard set and clear through an LSU write
        issue_i = 1'b1; issue_addr_i = 5'd5;
        cyc();
        idle();
        rs1_addr_i = 5'd5;
        #1;
        chk("sb_hazard_set", hazard_o, 1'b1);
        lsu_valid_i = 1'b1; lsu_addr_i = 5'd5; lsu_data_i = 32'hABCD;
        cyc();
        lsu_valid_i = 1'b0;
        cyc();
        chk("sb_wen", wen_o, 1'b1);
        chk("sb_data", wd_o, 32'hABCD);
`ifdef WB_FWD_EN
        chk("sb_fwd1", fwd1_o, 1'b1);
        chk("sb_hazard_wen", hazard_o, 1'b0);
`else
        chk("sb_hazard_wen", hazard_o, 1'b1);
`endif
        cyc();
        chk("sb_hazard_clr", hazard_o, 1'b0);

        // x0 writes and issues
        idle();
        alu_valid_i = 1'b1; alu_addr_i = 5'd0; alu_data_i = 32'h55;
        cyc();
        chk("x0_alu_wen", wen_o, 1'b0);
        idle();
        lsu_valid_i = 1'b1; lsu_addr_i = 5'd0; lsu_data_i = 32'h66;
        cyc();
        idle();
        cyc();
        chk("x0_lsu_wen", wen_o, 1'b0);
        chk("x0_ready", lsu_ready_o, 1'b1);
        issue_i = 1'b1; issue_addr_i = 5'd0;
        cyc();
        idle();
        #1;
        chk("x0_hazard", hazard_o, 1'b0);

        // Issue and LSU commit to x6 on the same edge: set wins
        issue_i = 1'b1; issue_addr_i = 5'd6;
        cyc();
        idle();
        lsu_valid_i = 1'b1; lsu_addr_i = 5'd6; lsu_data_i = 32'h6;
        cyc();
        idle();
        cyc();
        chk("simul_wen", wen_o, 1'b1);
        issue_i = 1'b1; issue_addr_i = 5'd6;
        cyc();
        idle();
        rs1_addr_i = 5'd6;
        #1;
        chk("simul_hazard", hazard_o, 1'b1);

        // Reset with two entries in flight
        alu_valid_i = 1'b1; alu_addr_i = 5'd1; alu_data_i = 32'h1;
        lsu_valid_i = 1'b1; lsu_addr_i = 5'd9; lsu_data_i = 32'h99;
        cyc();
        lsu_addr_i = 5'd10; lsu_data_i = 32'hAA;
        cyc();
        chk("mid_full", lsu_ready_o, 1'b0);
        idle();
        rs1_addr_i = 5'd6;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("mid_ready", lsu_ready_o, 1'b1);
        chk("mid_wen", wen_o, 1'b0);
        chk("mid_hazard", hazard_o, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("mid_no_write", wen_o, 1'b0);
        end

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            alu_valid_i  = ($urandom_range(0, 99) < 45);
            alu_addr_i   = 5'($urandom_range(0, 7));
            alu_data_i   = $urandom;
            lsu_valid_i  = ($urandom_range(0, 99) < 60);
            lsu_addr_i   = 5'($urandom_range(0, 7));
            lsu_data_i   = $urandom;
            issue_i      = ($urandom_range(0, 99) < 25);
            issue_addr_i = 5'($urandom_range(0, 7));
            rs1_addr_i   = 5'($urandom_range(0, 7));
            rs2_addr_i   = 5'($urandom_range(0, 7));
            rst          = ($urandom_range(0, 299) == 0);
            cyc();
            rst = 1'b0;
        end
        idle();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
